// File: rtl/fractal_sync_pkg.sv
// -----------------------------------------------------------------------------
// fractal_sync_pkg
// Shared types and constants for the fractal synchronization tree.
//   rf_e          : register-file flavour (1D or 2D) of a node
//   fsync_rsp_t   : wake response travelling down the tree
//   out_ports()   : number of independent response ports for a flavour
// -----------------------------------------------------------------------------
package fractal_sync_pkg;

  typedef enum logic {
    RF1D = 1'b0,
    RF2D = 1'b1
  } rf_e;

  localparam int unsigned LVL_WIDTH = 4;
  localparam int unsigned ID_WIDTH  = 8;

  typedef struct packed {
    logic                 wake;
    logic [LVL_WIDTH-1:0] lvl;
    logic [ID_WIDTH-1:0]  id;
    logic                 error;
  } fsync_rsp_t;

  // A 2D register file serves two independent directions, a 1D file one.
  function automatic int unsigned out_ports(input rf_e rf);
    case (rf)
      RF1D:    return 1;
      default: return 2;
    endcase
  endfunction

endpackage

// File: rtl/fractal_sync_rsp_port.sv
// -----------------------------------------------------------------------------
// fractal_sync_rsp_port
// One response port of the node's return path: round-robin arbitration between
// a local barrier response and a parent response, a FIFO_DEPTH-entry buffer,
// and a broadcast of the buffer head to both child links.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   local_rsp_i/valid_i/ready_o   local barrier-match response (valid/ready)
//   up_rsp_i/valid_i/ready_o      response returning from the parent
//   down_rsp_o/valid_o/ready_i    response to child 0 / child 1
//   err_o                         one-cycle pulse after accepting a bad level
//   empty_o                       buffer empty (no broadcast pending)
// -----------------------------------------------------------------------------
module fractal_sync_rsp_port
  import fractal_sync_pkg::*;
#(
  parameter int unsigned NODE_LVL    = 1,
  parameter int unsigned FIFO_DEPTH  = 2,
  parameter type         fsync_rsp_t = fractal_sync_pkg::fsync_rsp_t
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  fsync_rsp_t       local_rsp_i,
  input  logic             local_valid_i,
  output logic             local_ready_o,
  input  fsync_rsp_t       up_rsp_i,
  input  logic             up_valid_i,
  output logic             up_ready_o,
  output fsync_rsp_t [1:0] down_rsp_o,
  output logic       [1:0] down_valid_o,
  input  logic       [1:0] down_ready_i,
  output logic             err_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [LVL_WIDTH-1:0] NODE_LVL_L = LVL_WIDTH'(NODE_LVL);

  if (FIFO_DEPTH < 1) begin : g_bad_depth
    $error("fractal_sync_rsp_port: FIFO_DEPTH must be >= 1");
  end

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             favour_up_q, favour_up_d;  // 0: local favoured, 1: parent
  logic [1:0]       sent_q, sent_d;            // head already taken by child c
  logic             err_q, err_d;
  fsync_rsp_t       mem_q [FIFO_DEPTH];

  logic       fifo_empty, fifo_full;
  logic       push, pop, push_err;
  fsync_rsp_t push_data;
  logic [1:0] child_hs, child_done;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));

  // Readies depend only on registered state and the valids, so a full buffer
  // blocks both sources even if the head pops in the same cycle.
  always_comb begin
    local_ready_o = 1'b0;
    up_ready_o    = 1'b0;
    if (!fifo_full) begin
      if (local_valid_i && !up_valid_i) begin
        local_ready_o = 1'b1;
      end else if (up_valid_i && !local_valid_i) begin
        up_ready_o = 1'b1;
      end else begin
        local_ready_o = !favour_up_q;
        up_ready_o    = favour_up_q;
      end
    end
  end

  // The pointer only moves when both sources actually competed for a slot.
  assign favour_up_d = (local_valid_i && up_valid_i && !fifo_full) ? !favour_up_q
                                                                    : favour_up_q;

  // Level check at accept: locals must match this level exactly, parent
  // responses must come from strictly above. Bad entries are still forwarded.
  always_comb begin
    push      = 1'b0;
    push_err  = 1'b0;
    push_data = local_rsp_i;
    if (local_valid_i && local_ready_o) begin
      push      = 1'b1;
      push_data = local_rsp_i;
      push_err  = (local_rsp_i.lvl != NODE_LVL_L);
    end else if (up_valid_i && up_ready_o) begin
      push      = 1'b1;
      push_data = up_rsp_i;
      push_err  = (up_rsp_i.lvl <= NODE_LVL_L);
    end
    if (push_err) begin
      push_data.error = 1'b1;
    end
  end

  // Broadcast: each child takes the head once; the head leaves when both have.
  assign down_valid_o = {2{!fifo_empty}} & ~sent_q;
  assign child_hs     = down_valid_o & down_ready_i;
  assign child_done   = sent_q | child_hs;
  assign pop          = !fifo_empty && (&child_done);
  assign sent_d       = pop ? 2'b00 : child_done;

  for (genvar gi = 0; gi < 2; gi++) begin : g_child
    assign down_rsp_o[gi] = fifo_empty ? '0 : mem_q[rd_ptr_q];
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
  assign rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
  assign count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  assign err_d    = push && push_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      favour_up_q <= 1'b0;
      sent_q      <= 2'b00;
      err_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      favour_up_q <= favour_up_d;
      sent_q      <= sent_d;
      err_q       <= err_d;
    end
  end

  // Storage needs no reset: contents are only visible while count_q > 0.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign err_o   = err_q;
  assign empty_o = fifo_empty;

endmodule

// File: rtl/fractal_sync_rc.sv
// -----------------------------------------------------------------------------
// fractal_sync_rc
// Response-side control of a fractal synchronization node. Each of the
// OUT_PORTS ports independently merges local barrier matches and parent
// responses and broadcasts them to its two child links.
//
// Ports (per port p, child c):
//   clk_i, rst_ni                       clock, asynchronous active-low reset
//   local_rsp_i[p]/valid_i/ready_o      local barrier-match response
//   up_rsp_i[p]/valid_i/ready_o         response from the parent node
//   down_rsp_o[p][c]/valid_o/ready_i    response to child c
//   err_o[p]                            level-error pulse
//   empty_o                             every port buffer empty
// -----------------------------------------------------------------------------
module fractal_sync_rc
  import fractal_sync_pkg::*;
#(
  parameter rf_e         RF_TYPE     = RF2D,
  parameter int unsigned NODE_LVL    = 1,
  parameter int unsigned FIFO_DEPTH  = 2,
  parameter type         fsync_rsp_t = fractal_sync_pkg::fsync_rsp_t,
  localparam int unsigned OUT_PORTS  = out_ports(RF_TYPE)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  fsync_rsp_t [OUT_PORTS-1:0]       local_rsp_i,
  input  logic       [OUT_PORTS-1:0]       local_valid_i,
  output logic       [OUT_PORTS-1:0]       local_ready_o,
  input  fsync_rsp_t [OUT_PORTS-1:0]       up_rsp_i,
  input  logic       [OUT_PORTS-1:0]       up_valid_i,
  output logic       [OUT_PORTS-1:0]       up_ready_o,
  output fsync_rsp_t [OUT_PORTS-1:0][1:0]  down_rsp_o,
  output logic       [OUT_PORTS-1:0][1:0]  down_valid_o,
  input  logic       [OUT_PORTS-1:0][1:0]  down_ready_i,
  output logic       [OUT_PORTS-1:0]       err_o,
  output logic                             empty_o
);

  logic [OUT_PORTS-1:0] port_empty;

  for (genvar gi = 0; gi < OUT_PORTS; gi++) begin : g_port
    fractal_sync_rsp_port #(
      .NODE_LVL    (NODE_LVL),
      .FIFO_DEPTH  (FIFO_DEPTH),
      .fsync_rsp_t (fsync_rsp_t)
    ) i_port (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .local_rsp_i   (local_rsp_i[gi]),
      .local_valid_i (local_valid_i[gi]),
      .local_ready_o (local_ready_o[gi]),
      .up_rsp_i      (up_rsp_i[gi]),
      .up_valid_i    (up_valid_i[gi]),
      .up_ready_o    (up_ready_o[gi]),
      .down_rsp_o    (down_rsp_o[gi]),
      .down_valid_o  (down_valid_o[gi]),
      .down_ready_i  (down_ready_i[gi]),
      .err_o         (err_o[gi]),
      .empty_o       (port_empty[gi])
    );
  end

  assign empty_o = &port_empty;

endmodule

// File: tb/tb_fractal_sync_rc.sv
module tb_fractal_sync_rc;
  import fractal_sync_pkg::*;

  localparam int NP    = 2;
  localparam int DEPTH = 2;
  localparam int NLVL  = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fsync_rsp_t [NP-1:0]      l_rsp, u_rsp;
  logic       [NP-1:0]      l_v, l_r, u_v, u_r, err;
  fsync_rsp_t [NP-1:0][1:0] d_rsp;
  logic       [NP-1:0][1:0] d_v, d_r;
  logic                     empty;

  int errors = 0;
  int checks = 0;

  fractal_sync_rc #(
    .RF_TYPE    (RF2D),
    .NODE_LVL   (NLVL),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .local_rsp_i   (l_rsp),
    .local_valid_i (l_v),
    .local_ready_o (l_r),
    .up_rsp_i      (u_rsp),
    .up_valid_i    (u_v),
    .up_ready_o    (u_r),
    .down_rsp_o    (d_rsp),
    .down_valid_o  (d_v),
    .down_ready_i  (d_r),
    .err_o         (err),
    .empty_o       (empty)
  );

  // ---------------- reference model (queues per port) ----------------
  fsync_rsp_t mq [NP][$];
  bit         fav_up [NP];
  bit         snt [NP][2];
  bit         errx [NP];
  bit         e_lr [NP];
  bit         e_ur [NP];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic fsync_rsp_t mk(input int id, input int lvl);
    fsync_rsp_t r;
    r       = '0;
    r.wake  = 1'b1;
    r.lvl   = LVL_WIDTH'(lvl);
    r.id    = ID_WIDTH'(id);
    return r;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      mq[p].delete();
      fav_up[p] = 0;
      snt[p][0] = 0;
      snt[p][1] = 0;
      errx[p]   = 0;
    end
  endtask

  // Compare DUT against the model for the current cycle, then advance the
  // model by the transfers that the coming clock edge performs.
  task automatic model_step();
    bit all_empty;
    all_empty = 1;
    for (int p = 0; p < NP; p++) begin
      bit full, elr, eur, pop;
      bit ev [2];
      bit hs [2];
      fsync_rsp_t pr;
      full = (mq[p].size() >= DEPTH);
      elr = 0;
      eur = 0;
      if (!full) begin
        if (l_v[p] && !u_v[p])      elr = 1;
        else if (u_v[p] && !l_v[p]) eur = 1;
        else if (fav_up[p])         eur = 1;
        else                        elr = 1;
      end
      chk($sformatf("local_ready[%0d]", p), 32'(l_r[p]), 32'(elr));
      chk($sformatf("up_ready[%0d]", p), 32'(u_r[p]), 32'(eur));
      chk($sformatf("err[%0d]", p), 32'(err[p]), 32'(errx[p]));
      for (int c = 0; c < 2; c++) begin
        ev[c] = (mq[p].size() > 0) && !snt[p][c];
        chk($sformatf("down_valid[%0d][%0d]", p, c), 32'(d_v[p][c]), 32'(ev[c]));
        if (ev[c]) chk($sformatf("down_rsp[%0d][%0d]", p, c), 32'(d_rsp[p][c]), 32'(mq[p][0]));
        hs[c] = ev[c] && d_r[p][c];
      end
      if (mq[p].size() > 0) all_empty = 0;
      pop = (mq[p].size() > 0) && (snt[p][0] || hs[0]) && (snt[p][1] || hs[1]);
      if (pop) begin
        void'(mq[p].pop_front());
        snt[p][0] = 0;
        snt[p][1] = 0;
      end else begin
        snt[p][0] = snt[p][0] | hs[0];
        snt[p][1] = snt[p][1] | hs[1];
      end
      errx[p] = 0;
      if (l_v[p] && elr) begin
        pr = l_rsp[p];
        if (int'(pr.lvl) != NLVL) begin pr.error = 1'b1; errx[p] = 1; end
        mq[p].push_back(pr);
      end else if (u_v[p] && eur) begin
        pr = u_rsp[p];
        if (int'(pr.lvl) <= NLVL) begin pr.error = 1'b1; errx[p] = 1; end
        mq[p].push_back(pr);
      end
      if (l_v[p] && u_v[p] && !full) fav_up[p] = !fav_up[p];
      e_lr[p] = elr;
      e_ur[p] = eur;
    end
    chk("empty", 32'(empty), 32'(all_empty));
  endtask

  // ---------------- helpers ----------------
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    l_v = '0; u_v = '0; l_rsp = '0; u_rsp = '0; d_r = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    model_reset();
    nxt();
    nxt();
    rst_n = 1'b1;
  endtask

  // ---------------- arbiter / level-check vector table ----------------
  typedef struct {
    bit lv; int llvl; bit uv; int ulvl;
    bit exp_lr; bit exp_ur; bit exp_err; int exp_id;
  } vec_t;
  vec_t vt [10];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin : main
    int prev_id, li, ui;

    // local id 'h11, parent id 'h22; fresh reset favours local
    vt = '{
      '{0, 0, 0, 0,  1, 0, 0, -1},
      '{1, 1, 0, 0,  1, 0, 0, 'h11},
      '{0, 0, 1, 2,  0, 1, 0, 'h22},
      '{1, 1, 1, 3,  1, 0, 0, 'h11},
      '{1, 2, 0, 0,  1, 0, 1, 'h11},
      '{1, 0, 0, 0,  1, 0, 1, 'h11},
      '{0, 0, 1, 1,  0, 1, 1, 'h22},
      '{0, 0, 1, 0,  0, 1, 1, 'h22},
      '{0, 0, 1, 15, 0, 1, 0, 'h22},
      '{1, 3, 1, 1,  1, 0, 1, 'h11}
    };

    // reset state
    idle();
    rst_n = 1'b0;
    #2;
    chk("reset down_valid", 32'(d_v), 32'h0);
    chk("reset down_rsp", 32'(d_rsp[0][0]) | 32'(d_rsp[1][1]), 32'h0);
    chk("reset err", 32'(err), 32'h0);
    chk("reset empty", 32'(empty), 32'h1);
    chk("reset local_ready", 32'(l_r), 32'h3);
    chk("reset up_ready", 32'(u_r), 32'h0);
    $display("reset: outputs sampled");

    for (int i = 0; i < 10; i++) begin
      int p;
      p = i % 2;
      do_reset();
      d_r[p] = 2'b11;
      l_v[p] = vt[i].lv; l_rsp[p] = mk('h11, vt[i].llvl);
      u_v[p] = vt[i].uv; u_rsp[p] = mk('h22, vt[i].ulvl);
      @(negedge clk);
      chk($sformatf("vec%0d local_ready", i), 32'(l_r[p]), 32'(vt[i].exp_lr));
      chk($sformatf("vec%0d up_ready", i), 32'(u_r[p]), 32'(vt[i].exp_ur));
      nxt();
      l_v = '0; u_v = '0;
      @(negedge clk);
      chk($sformatf("vec%0d err", i), 32'(err[p]), 32'(vt[i].exp_err));
      chk($sformatf("vec%0d other err", i), 32'(err[1-p]), 32'h0);
      if (vt[i].exp_id >= 0) begin
        chk($sformatf("vec%0d down_valid", i), 32'(d_v[p]), 32'h3);
        chk($sformatf("vec%0d id", i), 32'(d_rsp[p][1].id), 32'(vt[i].exp_id));
        chk($sformatf("vec%0d error bit", i), 32'(d_rsp[p][0].error), 32'(vt[i].exp_err));
      end else begin
        chk($sformatf("vec%0d down_valid", i), 32'(d_v[p]), 32'h0);
      end
      $display("vec %0d: port %0d lv=%0d uv=%0d done", i, p, vt[i].lv, vt[i].uv);
    end

    // single local response, both children ready
    do_reset();
    d_r[0] = 2'b11;
    l_v[0] = 1; l_rsp[0] = mk(5, 1);
    @(negedge clk);
    chk("single local_ready", 32'(l_r[0]), 32'h1);
    nxt();
    l_v[0] = 0;
    @(negedge clk);
    chk("single down_valid", 32'(d_v[0]), 32'h3);
    chk("single id", 32'(d_rsp[0][0].id), 32'd5);
    chk("single error", 32'(d_rsp[0][1].error), 32'h0);
    chk("single empty busy", 32'(empty), 32'h0);
    nxt();
    @(negedge clk);
    chk("single empty after", 32'(empty), 32'h1);
    chk("single down_valid after", 32'(d_v[0]), 32'h0);
    $display("seq single: id 5 broadcast");

    // contended grants alternate local/up
    do_reset();
    d_r[0] = 2'b11;
    li = 10; ui = 20; prev_id = 0;
    for (int k = 0; k < 4; k++) begin
      l_v[0] = 1; l_rsp[0] = mk(li, 1);
      u_v[0] = 1; u_rsp[0] = mk(ui, 2);
      @(negedge clk);
      chk($sformatf("rr%0d local_ready", k), 32'(l_r[0]), 32'(k % 2 == 0));
      chk($sformatf("rr%0d up_ready", k), 32'(u_r[0]), 32'(k % 2 == 1));
      if (k > 0) chk($sformatf("rr%0d down id", k), 32'(d_rsp[0][0].id), 32'(prev_id));
      if (k % 2 == 0) begin prev_id = li; li++; end
      else begin prev_id = ui; ui++; end
      nxt();
    end
    l_v[0] = 0; u_v[0] = 0;
    @(negedge clk);
    chk("rr last id", 32'(d_rsp[0][0].id), 32'd21);
    $display("seq rr: order 10,20,11,21");

    // child 1 stalls three cycles on port 1
    do_reset();
    d_r[1] = 2'b01;
    l_v[1] = 1; l_rsp[1] = mk(7, 1);
    nxt();
    l_v[1] = 0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk($sformatf("stall%0d child0 valid", s), 32'(d_v[1][0]), 32'(s == 0));
      chk($sformatf("stall%0d child1 valid", s), 32'(d_v[1][1]), 32'h1);
      chk($sformatf("stall%0d empty", s), 32'(empty), 32'h0);
      nxt();
    end
    d_r[1] = 2'b11;
    @(negedge clk);
    chk("stall release id", 32'(d_rsp[1][1].id), 32'd7);
    chk("stall release child0", 32'(d_v[1][0]), 32'h0);
    nxt();
    @(negedge clk);
    chk("stall popped valid", 32'(d_v[1]), 32'h0);
    chk("stall popped empty", 32'(empty), 32'h1);
    $display("seq stall: id 7 delivered to child 1 after stall");

    // fill the buffer with three parent responses
    do_reset();
    u_v[0] = 1; u_rsp[0] = mk(30, 2);
    @(negedge clk);
    chk("full up_ready 0", 32'(u_r[0]), 32'h1);
    nxt();
    u_rsp[0] = mk(31, 2);
    @(negedge clk);
    chk("full up_ready 1", 32'(u_r[0]), 32'h1);
    nxt();
    u_rsp[0] = mk(32, 2);
    @(negedge clk);
    chk("full up_ready 2", 32'(u_r[0]), 32'h0);
    chk("full local_ready", 32'(l_r[0]), 32'h0);
    chk("full head", 32'(d_rsp[0][0].id), 32'd30);
    nxt();
    d_r[0] = 2'b11;
    @(negedge clk);
    chk("full no fallthrough", 32'(u_r[0]), 32'h0);
    chk("full drain 30", 32'(d_rsp[0][1].id), 32'd30);
    nxt();
    @(negedge clk);
    chk("full up_ready freed", 32'(u_r[0]), 32'h1);
    chk("full drain 31", 32'(d_rsp[0][0].id), 32'd31);
    nxt();
    u_v[0] = 0;
    @(negedge clk);
    chk("full drain 32", 32'(d_rsp[0][0].id), 32'd32);
    nxt();
    @(negedge clk);
    chk("full empty", 32'(empty), 32'h1);
    $display("seq full: 30,31,32 drained in order");

    // reset with two entries and a partial broadcast in flight
    do_reset();
    d_r[0] = 2'b01;
    l_v[0] = 1; l_rsp[0] = mk(40, 1);
    nxt();
    l_rsp[0] = mk(41, 1);
    nxt();
    l_v[0] = 0;
    @(negedge clk);
    chk("midrst partial", 32'(d_v[0]), 32'h2);
    rst_n = 1'b0;
    #1;
    chk("midrst down_valid", 32'(d_v), 32'h0);
    chk("midrst empty", 32'(empty), 32'h1);
    chk("midrst err", 32'(err), 32'h0);
    nxt();
    rst_n = 1'b1;
    d_r[0] = 2'b11;
    l_v[0] = 1; l_rsp[0] = mk(50, 1);
    @(negedge clk);
    chk("midrst local_ready", 32'(l_r[0]), 32'h1);
    nxt();
    l_v[0] = 0;
    @(negedge clk);
    chk("midrst new valid", 32'(d_v[0]), 32'h3);
    chk("midrst new id", 32'(d_rsp[0][0].id), 32'd50);
    nxt();
    @(negedge clk);
    chk("midrst new empty", 32'(empty), 32'h1);
    $display("seq midrst: buffer discarded, id 50 passed");

    // randomized traffic against the model, three child-readiness regimes
    for (int ph = 0; ph < 3; ph++) begin
      int rdy_pct;
      rdy_pct = (ph == 0) ? 90 : (ph == 1) ? 50 : 20;
      do_reset();
      for (int cyc = 0; cyc < 600; cyc++) begin
        logic [NP-1:0] n_lv, n_uv;
        fsync_rsp_t [NP-1:0] n_lrsp, n_ursp;
        logic [NP-1:0][1:0] n_dr;
        @(negedge clk);
        model_step();
        for (int p = 0; p < NP; p++) begin
          n_lv[p] = l_v[p]; n_lrsp[p] = l_rsp[p];
          n_uv[p] = u_v[p]; n_ursp[p] = u_rsp[p];
          if (!l_v[p] || e_lr[p]) begin
            n_lv[p]   = ($urandom_range(0, 99) < 55);
            n_lrsp[p] = mk($urandom_range(0, 255),
                           ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : 1);
          end
          if (!u_v[p] || e_ur[p]) begin
            n_uv[p]   = ($urandom_range(0, 99) < 55);
            n_ursp[p] = mk($urandom_range(0, 255), $urandom_range(0, 4));
          end
          for (int c = 0; c < 2; c++) n_dr[p][c] = ($urandom_range(0, 99) < rdy_pct);
        end
        @(posedge clk);
        #1;
        l_v = n_lv; l_rsp = n_lrsp; u_v = n_uv; u_rsp = n_ursp; d_r = n_dr;
      end
      $display("random phase %0d: child ready %0d%%, 600 cycles", ph, rdy_pct);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fractal_sync_rc.md
Name: fractal_sync_rc

Overview:
- Response-side control of a fractal synchronization node; the return path that complements the node's request-side core control.
- Collects wake responses from two sources per port: local barrier matches reported by the node, and responses returning from the parent node.
- Per port: arbitrates the two sources, buffers the winner, then broadcasts each response to both child links of that port.
- Sits between the node's request logic / upstream links and the downstream child links.

Parameters:
- RF_TYPE, fractal_sync_pkg::RF2D; register-file flavour. Sets OUT_PORTS: RF2D=2, RF1D=1.
- NODE_LVL, 1; tree level of this node (root-relative, leaves=1).
- FIFO_DEPTH, 2; entries per port buffer. Must be >=1; elaboration error otherwise.
- fsync_rsp_t, logic; response struct from fractal_sync_pkg.
- OUT_PORTS, localparam; derived from RF_TYPE.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- local_rsp_i  in  [OUT_PORTS] fsync_rsp_t  response from a local barrier match.
- local_valid_i  in  [OUT_PORTS]  local response valid.
- local_ready_o  out  [OUT_PORTS]  local response accepted.
- up_rsp_i  in  [OUT_PORTS] fsync_rsp_t  response from the parent.
- up_valid_i  in  [OUT_PORTS]  parent response valid.
- up_ready_o  out  [OUT_PORTS]  parent response accepted.
- down_rsp_o  out  [OUT_PORTS][2] fsync_rsp_t  response to child 0/1.
- down_valid_o  out  [OUT_PORTS][2]  child response valid.
- down_ready_i  in  [OUT_PORTS][2]  child accepts.
- err_o  out  [OUT_PORTS]  one-cycle level-error pulse.
- empty_o  out  1  all port buffers empty and no broadcast pending.

Behaviour:
- Reset: all FIFOs empty, all sent flags cleared, RR pointers set to local. Outputs at reset: down_valid_o=0, down_rsp_o=0, err_o=0, empty_o=1. local_ready_o and up_ready_o follow the arbiter rule (high for the favoured source when not full).
- Reset mid-operation discards all buffered responses. There is no partial-broadcast recovery.
- Ports are fully independent; rules below apply per port.
- Handshake: valid/ready. A source holds valid and data stable until ready. Transfer occurs on a cycle with valid&&ready.
- Input ready never depends on the same-cycle pop (no fall-through). FIFO full means both readies are 0.
- Arbiter, FIFO not full:
  - Only one source valid: that source's ready=1.
  - Neither source valid: the ready of the source favoured by the RR pointer is 1, the other 0.
  - Both valid: the source favoured by the RR pointer wins. The pointer flips only after a contended grant.
  - At most one push per cycle.
- Level check, applied at accept:
  - Local response with lvl != NODE_LVL is an error.
  - Upstream response with lvl <= NODE_LVL is an error.
  - On error: err_o pulses the cycle after accept, and the entry is still buffered with its error field forced to 1.
- Latency: accept at cycle t gives down_valid_o at t+1 (registered FIFO). There is no combinational input-to-output path.
- Broadcast of the FIFO head:
  - down_valid_o[p][c] = !empty && !sent_q[p][c], with the same head data on both children.
  - A handshake on child c sets sent_q[p][c].
  - The head pops when both children have completed: either both in the same cycle, or the second completes while the first's flag is already set. On pop, both flags clear.
- Simultaneous push and pop while full: no push that cycle, because ready was 0.
- Simultaneous push and pop at intermediate occupancy: occupancy is unchanged.
- Pointers wrap modulo FIFO_DEPTH. The count ranges 0..FIFO_DEPTH.
- empty_o = AND over ports of FIFO empty.

Decomposition:
- fractal_sync_pkg gains:
  - fsync_rsp_t: wake, lvl[LVL_WIDTH], id[ID_WIDTH], error.
  - LVL_WIDTH and ID_WIDTH constants.
  - A helper function returning OUT_PORTS for an rf_e.
- Sub-module fractal_sync_rsp_port: per-port arbiter, FIFO, broadcast and error logic. Top-level is a generate loop over OUT_PORTS.

Test Plan:
- Single local response, NODE_LVL=1, lvl=1, id=5, children always ready → down_valid_o on both children at t+1 with id=5, error=0; pop at t+1; empty_o returns to 1 at t+2.
- Local and upstream valid together, 4 cycles, FIFO never full → grants alternate local, up, local, up; pushed ids appear in that order downstream.
- Child 0 ready, child 1 stalled 3 cycles, response id=7 → child 0 sees one handshake only; child 1 valid stays high until its ready; the head pops the same cycle child 1 accepts.
- FIFO_DEPTH=2, both children held not-ready, 3 upstream responses (lvl=2) → first two accepted, then up_ready_o=0; releasing the children drains them in order and the third is accepted.
- Upstream response lvl=1 at NODE_LVL=1 → err_o pulses 1 cycle after accept; forwarded entry has error=1.
- Assert rst_ni low with 2 entries buffered and a partial broadcast in flight → immediately down_valid_o=0, empty_o=1; after release the first new response passes normally.
